// File: rtl/tail_light_monitor.sv
// Passive receiver for the two 3-bit tail-light buses: recovers driver intent
// per side and reports illegal patterns, illegal steps, too-fast steps and stuck walks.

module tail_light_channel #(
   parameter int STEP_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] light_i,
   output logic [1:0] mode_o,
   output logic       err_o,
   output logic [1:0] err_code_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      MODE_IDLE = 2'b00,
      MODE_ON   = 2'b01,
      MODE_UP   = 2'b10,
      MODE_DOWN = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ERR_STUCK   = 2'b00,
      ERR_PATTERN = 2'b01,
      ERR_TRANS   = 2'b10,
      ERR_FAST    = 2'b11
   } err_e;

   function automatic logic legal_pat(input logic [2:0] p);
      return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
   endfunction

   function automatic logic up_step(input logic [2:0] a, input logic [2:0] b);
      logic res;
      case (a)
         3'b000:  res = (b == 3'b001);
         3'b001:  res = (b == 3'b011);
         3'b011:  res = (b == 3'b111);
         3'b111:  res = (b == 3'b000);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic down_step(input logic [2:0] a, input logic [2:0] b);
      return up_step(b, a);
   endfunction

   logic [2:0]       cur_q;
   logic [2:0]       prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   mode_e            mode_q;
   logic             err_q;
   err_e             code_q;
   logic             armed_q;

   logic change_w;
   logic fast_w;
   logic timeout_w;

   assign change_w  = (cur_q != prev_q);
   assign fast_w    = (cnt_q < CNT_FAST);
   // Only the 19->20 increment fires; a saturated counter never re-fires.
   assign timeout_w = !change_w && (cnt_q == CNT_TO);

   always_comb begin
      cnt_d = cnt_q;
      if (change_w) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q   <= 3'b000;
         prev_q  <= 3'b000;
         cnt_q   <= CNT_SAT;
         mode_q  <= MODE_IDLE;
         err_q   <= 1'b0;
         code_q  <= ERR_STUCK;
         armed_q <= 1'b0;
      end else begin
         cur_q  <= light_i;
         prev_q <= cur_q;
         cnt_q  <= cnt_d;
         err_q  <= 1'b0;
         if (change_w) begin
            // The first change after reset is measured against the reset value
            // 000, which says nothing about the sender's real previous pattern.
            armed_q <= 1'b1;
            if (!legal_pat(cur_q)) begin
               err_q  <= 1'b1;
               code_q <= ERR_PATTERN;
            end else if (up_step(prev_q, cur_q)) begin
               mode_q <= MODE_UP;
               if (fast_w) begin
                  err_q  <= 1'b1;
                  code_q <= ERR_FAST;
               end
            end else if (down_step(prev_q, cur_q)) begin
               mode_q <= MODE_DOWN;
               if (fast_w) begin
                  err_q  <= 1'b1;
                  code_q <= ERR_FAST;
               end
            end else if (armed_q) begin
               err_q  <= 1'b1;
               code_q <= ERR_TRANS;
            end
         end else if (timeout_w) begin
            case (cur_q)
               3'b000: mode_q <= MODE_IDLE;
               3'b111: mode_q <= MODE_ON;
               3'b001, 3'b011: begin
                  mode_q <= MODE_IDLE;
                  err_q  <= 1'b1;
                  code_q <= ERR_STUCK;
               end
               default: ;
            endcase
         end
      end
   end

   assign mode_o     = mode_q;
   assign err_o      = err_q;
   assign err_code_o = code_q;

endmodule

module tail_light_monitor #(
   parameter int STEP_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] right_light,
   input  logic [2:0] left_light,
   input  logic       clr_err_count,
   output logic [1:0] right_mode,
   output logic [1:0] left_mode,
   output logic       turn_right_det,
   output logic       turn_left_det,
   output logic       brake_det,
   output logic       right_err,
   output logic       left_err,
   output logic [1:0] right_err_code,
   output logic [1:0] left_err_code,
   output logic [7:0] err_count
);

   tail_light_channel #(
      .STEP_CYCLES    (STEP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_right (
      .clk        (clk),
      .rst_n      (rst_n),
      .light_i    (right_light),
      .mode_o     (right_mode),
      .err_o      (right_err),
      .err_code_o (right_err_code)
   );

   tail_light_channel #(
      .STEP_CYCLES    (STEP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_left (
      .clk        (clk),
      .rst_n      (rst_n),
      .light_i    (left_light),
      .mode_o     (left_mode),
      .err_o      (left_err),
      .err_code_o (left_err_code)
   );

   // Mode bit 1 marks UP/DOWN (turning); bit 0 marks ON/DOWN (braking).
   assign turn_right_det = right_mode[1];
   assign turn_left_det  = left_mode[1];
   assign brake_det      = right_mode[0] | left_mode[0];

   logic [1:0] err_inc_w;
   logic [8:0] err_sum_w;
   logic [7:0] err_count_d;
   logic [7:0] err_count_q;

   always_comb begin
      err_inc_w   = {1'b0, right_err} + {1'b0, left_err};
      err_sum_w   = {1'b0, err_count_q} + {7'b0, err_inc_w};
      err_count_d = err_sum_w[8] ? 8'hFF : err_sum_w[7:0];
      if (clr_err_count) begin
         err_count_d = {6'b0, err_inc_w};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_q <= 8'h00;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Directed bench for tail_light_monitor: ring-position model checked every cycle,
// plus literal expectations at the points the scenarios call out.

module tb_tail_light_monitor;

   localparam int STEP = 8;
   localparam int TOUT = 20;

   logic       clk;
   logic       rst_n;
   logic [2:0] right_light;
   logic [2:0] left_light;
   logic       clr_err_count;
   logic [1:0] right_mode;
   logic [1:0] left_mode;
   logic       turn_right_det;
   logic       turn_left_det;
   logic       brake_det;
   logic       right_err;
   logic       left_err;
   logic [1:0] right_err_code;
   logic [1:0] left_err_code;
   logic [7:0] err_count;

   tail_light_monitor #(.STEP_CYCLES(STEP), .TIMEOUT_CYCLES(TOUT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .right_light    (right_light),
      .left_light     (left_light),
      .clr_err_count  (clr_err_count),
      .right_mode     (right_mode),
      .left_mode      (left_mode),
      .turn_right_det (turn_right_det),
      .turn_left_det  (turn_left_det),
      .brake_det      (brake_det),
      .right_err      (right_err),
      .left_err       (left_err),
      .right_err_code (right_err_code),
      .left_err_code  (left_err_code),
      .err_count      (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Patterns sit on a ring 000,001,011,111; an up-step advances one position,
   // a down-step goes back one. Timing is tracked as edges since the last change.
   function automatic int ring_pos(input logic [2:0] p);
      case (p)
         3'b000:  return 0;
         3'b001:  return 1;
         3'b011:  return 2;
         3'b111:  return 3;
         default: return -1;
      endcase
   endfunction

   logic [2:0] cap1 [2];
   logic [2:0] cap2 [2];
   int         last_chg [2];
   bit         seen [2];
   logic [1:0] m_mode [2];
   logic       m_err [2];
   logic [1:0] m_code [2];
   int         m_count;
   int         edge_n;

   always @(posedge clk or negedge rst_n) begin
      int inc, gap, pc, pp, sum;
      logic [2:0] bus [2];
      if (!rst_n) begin
         for (int s = 0; s < 2; s++) begin
            cap1[s] = 3'b000; cap2[s] = 3'b000; last_chg[s] = -1000000;
            seen[s] = 1'b0; m_mode[s] = 2'b00; m_err[s] = 1'b0; m_code[s] = 2'b00;
         end
         m_count = 0;
         edge_n  = 0;
      end else begin
         inc = int'(m_err[0]) + int'(m_err[1]);
         sum = m_count + inc;
         m_count = clr_err_count ? inc : ((sum > 255) ? 255 : sum);
         edge_n++;
         bus[0] = right_light;
         bus[1] = left_light;
         for (int s = 0; s < 2; s++) begin
            m_err[s] = 1'b0;
            pc = ring_pos(cap1[s]);
            pp = ring_pos(cap2[s]);
            if (cap1[s] != cap2[s]) begin
               gap = edge_n - last_chg[s];
               last_chg[s] = edge_n;
               if (pc < 0) begin
                  m_err[s] = 1'b1; m_code[s] = 2'b01;
               end else if (pp >= 0 && pc == (pp + 1) % 4) begin
                  m_mode[s] = 2'b10;
                  if (gap < STEP) begin m_err[s] = 1'b1; m_code[s] = 2'b11; end
               end else if (pp == (pc + 1) % 4) begin
                  m_mode[s] = 2'b11;
                  if (gap < STEP) begin m_err[s] = 1'b1; m_code[s] = 2'b11; end
               end else if (seen[s]) begin
                  m_err[s] = 1'b1; m_code[s] = 2'b10;
               end
               seen[s] = 1'b1;
            end else if (edge_n - last_chg[s] == TOUT) begin
               if (pc == 0) m_mode[s] = 2'b00;
               else if (pc == 3) m_mode[s] = 2'b01;
               else if (pc > 0) begin
                  m_mode[s] = 2'b00; m_err[s] = 1'b1; m_code[s] = 2'b00;
               end
            end
            cap2[s] = cap1[s];
            cap1[s] = bus[s];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("cmp right_mode", 8'(right_mode), 8'(m_mode[0]));
         chk("cmp left_mode", 8'(left_mode), 8'(m_mode[1]));
         chk("cmp turn_right_det", 8'(turn_right_det),
             8'((m_mode[0] == 2'b10) || (m_mode[0] == 2'b11)));
         chk("cmp turn_left_det", 8'(turn_left_det),
             8'((m_mode[1] == 2'b10) || (m_mode[1] == 2'b11)));
         chk("cmp brake_det", 8'(brake_det),
             8'((m_mode[0] == 2'b01) || (m_mode[0] == 2'b11) ||
                (m_mode[1] == 2'b01) || (m_mode[1] == 2'b11)));
         chk("cmp right_err", 8'(right_err), 8'(m_err[0]));
         chk("cmp left_err", 8'(left_err), 8'(m_err[1]));
         if (m_err[0]) chk("cmp right_err_code", 8'(right_err_code), 8'(m_code[0]));
         if (m_err[1]) chk("cmp left_err_code", 8'(left_err_code), 8'(m_code[1]));
         chk("cmp err_count", err_count, 8'(m_count));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] r, input logic [2:0] l);
      right_light = r;
      left_light  = l;
   endtask

   initial begin
      rst_n = 1'b0;
      clr_err_count = 1'b0;
      drive(3'b000, 3'b000);
      wait_n(3);
      chk_en = 1'b1;
      chk("lit reset right_mode", 8'(right_mode), 8'd0);
      chk("lit reset left_mode", 8'(left_mode), 8'd0);
      chk("lit reset strobes", 8'({right_err, left_err, brake_det}), 8'd0);
      chk("lit reset err_count", err_count, 8'd0);
      rst_n = 1'b1;
      wait_n(30);

      // Turn right
      drive(3'b001, 3'b000);
      wait_n(2);
      chk("lit turn right_mode", 8'(right_mode), 8'b10);
      chk("lit turn turn_right_det", 8'(turn_right_det), 8'd1);
      chk("lit turn brake_det", 8'(brake_det), 8'd0);
      wait_n(6);
      drive(3'b011, 3'b000); wait_n(8);
      drive(3'b111, 3'b000); wait_n(8);
      drive(3'b000, 3'b000); wait_n(30);
      chk("lit turn no errors", err_count, 8'd0);

      // Brake only
      drive(3'b111, 3'b111);
      wait_n(2);
      chk("lit brake modes down", 8'({right_mode, left_mode}), 8'b1111);
      chk("lit brake brake_det", 8'(brake_det), 8'd1);
      wait_n(19);
      chk("lit brake still down", 8'({right_mode, left_mode}), 8'b1111);
      wait_n(1);
      chk("lit brake modes on", 8'({right_mode, left_mode}), 8'b0101);
      chk("lit brake brake_det on", 8'(brake_det), 8'd1);
      wait_n(5);
      chk("lit brake no errors", err_count, 8'd0);

      // Brake with right turn
      drive(3'b000, 3'b111); wait_n(30);
      drive(3'b111, 3'b111);
      wait_n(2);
      chk("lit bturn right_mode", 8'(right_mode), 8'b11);
      chk("lit bturn left_mode", 8'(left_mode), 8'b01);
      chk("lit bturn flags", 8'({turn_right_det, brake_det}), 8'b11);
      wait_n(6);
      drive(3'b011, 3'b111); wait_n(8);
      drive(3'b001, 3'b111); wait_n(8);
      chk("lit bturn right_mode late", 8'(right_mode), 8'b11);
      drive(3'b000, 3'b111); wait_n(30);
      drive(3'b000, 3'b000); wait_n(30);
      chk("lit bturn no errors", err_count, 8'd0);

      // Fault injection on the right bus
      drive(3'b001, 3'b000); wait_n(8);
      drive(3'b111, 3'b000);
      wait_n(2);
      chk("lit fault trans err", 8'(right_err), 8'd1);
      chk("lit fault trans code", 8'(right_err_code), 8'b10);
      wait_n(1);
      drive(3'b011, 3'b000);
      wait_n(2);
      chk("lit fault fast err", 8'(right_err), 8'd1);
      chk("lit fault fast code", 8'(right_err_code), 8'b11);
      chk("lit fault fast mode", 8'(right_mode), 8'b11);
      wait_n(20);
      chk("lit fault stuck err", 8'(right_err), 8'd1);
      chk("lit fault stuck code", 8'(right_err_code), 8'b00);
      chk("lit fault stuck mode", 8'(right_mode), 8'b00);
      wait_n(1);
      chk("lit fault count 3", err_count, 8'd3);
      drive(3'b010, 3'b000);
      wait_n(2);
      chk("lit fault pattern err", 8'(right_err), 8'd1);
      chk("lit fault pattern code", 8'(right_err_code), 8'b01);
      wait_n(1);
      chk("lit fault count 4", err_count, 8'd4);
      drive(3'b000, 3'b000); wait_n(30);

      // Simultaneous errors with clear, then saturation
      drive(3'b101, 3'b101);
      clr_err_count = 1'b1;
      wait_n(1);
      clr_err_count = 1'b0;
      wait_n(1);
      chk("lit simul both strobes", 8'({right_err, left_err}), 8'b11);
      chk("lit simul codes", 8'({right_err_code, left_err_code}), 8'b0101);
      wait_n(1);
      chk("lit simul count 2", err_count, 8'd2);
      for (int i = 0; i < 126; i++) begin
         if (i % 2 == 0) drive(3'b010, 3'b010);
         else drive(3'b101, 3'b101);
         wait_n(1);
      end
      wait_n(3);
      chk("lit sat count 254", err_count, 8'd254);
      drive(3'b010, 3'b010);
      wait_n(3);
      chk("lit sat count 255", err_count, 8'd255);
      drive(3'b101, 3'b101);
      wait_n(2);
      clr_err_count = 1'b1;
      wait_n(1);
      clr_err_count = 1'b0;
      chk("lit clear keeps strobes", err_count, 8'd2);
      wait_n(30);
      drive(3'b000, 3'b000); wait_n(30);

      // Reset mid-walk
      drive(3'b001, 3'b000); wait_n(8);
      drive(3'b011, 3'b000); wait_n(4);
      chk("lit prereset right_mode", 8'(right_mode), 8'b10);
      rst_n = 1'b0;
      #1;
      chk("lit midreset modes", 8'({right_mode, left_mode}), 8'd0);
      chk("lit midreset flags", 8'({turn_right_det, turn_left_det, brake_det, right_err, left_err}), 8'd0);
      chk("lit midreset codes", 8'({right_err_code, left_err_code}), 8'd0);
      chk("lit midreset err_count", err_count, 8'd0);
      wait_n(2);
      rst_n = 1'b1;
      wait_n(2);
      chk("lit postreset no trans err", 8'(right_err), 8'd0);
      wait_n(20);
      chk("lit postreset stuck err", 8'(right_err), 8'd1);
      chk("lit postreset stuck code", 8'(right_err_code), 8'b00);
      chk("lit postreset right_mode", 8'(right_mode), 8'b00);
      wait_n(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tail_light_monitor.md
# tail_light_monitor

Decodes the two 3-bit tail-light drive buses back into driver intent (turn left, turn right, brake, brake-with-turn) and checks them for protocol violations. It is the receiving end of the tail-light control interface and sits on the light buses as a passive monitor, feeding the dashboard indicators and the fault logger. It detects illegal patterns, illegal steps, steps faster than the sequencer rate, and a sequence stuck mid-walk.

## Interface
- STEP_CYCLES, 8: nominal clock cycles between successive pattern updates on a bus.
- TIMEOUT_CYCLES, 20: cycles without change after which a bus is treated as steady. Must be greater than STEP_CYCLES.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- right_light  input  3  right tail-light bus.
- left_light  input  3  left tail-light bus.
- clr_err_count  input  1  synchronous clear of err_count.
- right_mode, left_mode  output  2 each  decoded side mode: 00 IDLE, 01 ON, 10 UP, 11 DOWN.
- turn_right_det, turn_left_det  output  1 each  side mode is UP or DOWN.
- brake_det  output  1  either side mode is ON or DOWN.
- right_err, left_err  output  1 each  single-cycle error strobe per side.
- right_err_code, left_err_code  output  2 each  error code, valid with its strobe: 00 stuck, 01 illegal pattern, 10 illegal transition, 11 too fast.
- err_count  output  8  saturating count of all error strobes.

## Operation
- Each side is an identical, independent channel: input register cur, previous register prev, change counter cnt, and mode FSM.
- Legal patterns are 000, 001, 011, 111.
- Up-steps are 000→001, 001→011, 011→111, 111→000.
- Down-steps are the reverse: 000→111, 111→011, 011→001, 001→000.
- Change means cur != prev. prev is loaded from cur every cycle. cnt is cleared to 0 on a change; otherwise it increments, saturating at TIMEOUT_CYCLES.
- On a change, the first matching rule applies:
  - cur is illegal: error 01, mode unchanged.
  - prev→cur is not an up-step or down-step: error 10, mode unchanged.
  - The step is legal and cnt < STEP_CYCLES-1: error 11, and the mode still updates (UP for an up-step, DOWN for a down-step).
  - Otherwise the mode updates to UP for an up-step or DOWN for a down-step, with no error.
- Timeout fires only on the cycle cnt increments from TIMEOUT_CYCLES-1 to TIMEOUT_CYCLES:
  - cur 000: mode IDLE.
  - cur 111: mode ON.
  - cur 001 or 011: mode IDLE and error 00 (stuck).
  - cur illegal: no action, because it was already reported on entry.
- After the timeout fires, the held pattern generates no further timeout events.
- err_count adds right_err + left_err each cycle, so it adds 2 when both sides strobe in the same cycle, and saturates at 255.
- clr_err_count loads err_count with that same cycle's increment, so strobes in the clear cycle are not lost.
- Decoded flags are combinational from the mode registers.

## Timing
- Reset values: cur = prev = 000, cnt = TIMEOUT_CYCLES (saturated, so there is no spurious timeout or too-fast error after reset), modes IDLE, all flags and strobes 0, err_count 0.
- A bus value present before edge k is captured in cur at edge k.
- Mode, error strobe and code update at edge k+1. Latency from bus to output is 2 edges.
- Error strobes are high for exactly one cycle per event.
- A timeout fires TIMEOUT_CYCLES+1 edges after the last change edge.
- Asserting reset mid-sequence returns every register to its reset value immediately. The first post-reset sample of a non-000 bus is judged as a change from 000.
- Both sides may strobe in the same cycle. Neither side's error is dropped or delayed.

## Test plan
- Turn right: drive right bus 000→001→011→111→000 every 8 cycles, left held at 000.
  - Required: right_mode 10 and turn_right_det 1 two edges after the first step.
  - Required: brake_det 0 and no errors.
- Brake only: both buses jump from 000 to 111 and hold.
  - Required: both modes 11 (DOWN) two edges after the jump.
  - Required: both modes 01 (ON) 21 edges after the jump.
  - Required: brake_det 1 throughout, no errors.
- Brake with right turn: left at 111; right walks 000→111→011→001→000 at 8-cycle intervals.
  - Required: right_mode 11 (DOWN), left_mode 01 (ON).
  - Required: turn_right_det 1, brake_det 1.
- Fault injection on the right bus:
  - Driving 010: right_err with code 01.
  - Stepping 001→111: code 10.
  - A legal step only 3 cycles after the previous change: code 11.
  - Holding 011 for 21 cycles: code 00 and right_mode 00.
  - Required: err_count = 4 after all four faults.
- Simultaneous errors with clear: both buses go to 101 in the same cycle as clr_err_count is asserted.
  - Required: right_err and left_err strobe together, and err_count = 2.
  - Preload 254, then repeat without clear: err_count saturates at 255.
- Reset mid-walk: assert rst_n low with right_mode UP and cnt mid-count.
  - Required: all outputs 0 immediately.
  - After release with right bus held at 011: right_mode becomes 00 after the timeout and code 00 is reported. No code 10 is reported for the 000→011 sample.
